// File: rtl/qoi_chunk_packer.sv
// qoi_chunk_packer
// Packs variable-length encoder chunks (0..4 bytes per cycle) into 32-bit
// words and queues them in a small output FIFO. On flush it appends the
// 8-byte end marker (00 00 00 00 00 00 00 01), pushes any final partial
// word, and then raises done.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   chunk        encoder chunk, left-justified (byte 0 = chunk[31:24])
//   chunk_bytes  valid bytes in chunk (0..4; 5..7 treated as 0)
//   flush        single-cycle end-of-image request
//   out_word     FIFO head word, left-justified
//   out_bytes    valid bytes in out_word (1..4), 0 when out_valid=0
//   out_valid    out_word holds a word
//   out_ready    consumer accepts the head word when out_valid && out_ready
//   overflow     sticky: a packed word was dropped because the FIFO was full
//   done         end marker and final partial word have been pushed
//
// state | meaning
// RUN   | packing encoder chunks; flush moves on to the marker
// MARK0 | injecting marker bytes 00 00 00 00
// MARK1 | injecting marker bytes 00 00 00 01
// TAIL  | pushing the leftover residual bytes as a short word
// DONE  | image complete; FIFO keeps draining until rst
module qoi_chunk_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] chunk,
    input  logic [2:0]  chunk_bytes,
    input  logic        flush,
    output logic [31:0] out_word,
    output logic [2:0]  out_bytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {RUN, MARK0, MARK1, TAIL, DONE} state_t;

    state_t      state, state_nxt;

    logic [23:0] res_data, res_data_nxt;
    logic [1:0]  res_cnt, res_cnt_nxt;

    logic [31:0] fifo_word  [FIFO_DEPTH];
    logic [2:0]  fifo_bytes [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, pop, can_push;

    logic [31:0] in_data, in_mask;
    logic [2:0]  in_cnt, total;
    logic [55:0] cat;

    logic        push, drop;
    logic [31:0] push_word;
    logic [2:0]  push_bytes;

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && out_ready;
    assign can_push   = !fifo_full || pop;

    assign out_valid  = !fifo_empty;
    assign out_word   = fifo_empty ? 32'h0 : fifo_word[rd_ptr[AW-1:0]];
    assign out_bytes  = fifo_empty ? 3'd0  : fifo_bytes[rd_ptr[AW-1:0]];
    assign done       = (state == DONE);

    // Input byte source: encoder in RUN, marker bytes in MARK0/MARK1.
    always_comb begin
        in_data = 32'h0;
        in_cnt  = 3'd0;
        case (state)
            RUN: begin
                in_data = chunk;
                in_cnt  = (chunk_bytes <= 3'd4) ? chunk_bytes : 3'd0;
            end
            MARK0: begin
                in_data = 32'h0000_0000;
                in_cnt  = 3'd4;
            end
            MARK1: begin
                in_data = 32'h0000_0001;
                in_cnt  = 3'd4;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_mask = 32'h0;
        case (in_cnt)
            3'd1:    in_mask = 32'hFF00_0000;
            3'd2:    in_mask = 32'hFFFF_0000;
            3'd3:    in_mask = 32'hFFFF_FF00;
            3'd4:    in_mask = 32'hFFFF_FFFF;
            default: in_mask = 32'h0;
        endcase
    end

    // Residual bytes first, new bytes appended right after them. The low two
    // bits of total are the residual count afterwards whether or not a word
    // is taken off the front (total is at most 7).
    assign cat   = {res_data, 32'h0} |
                   ({in_data & in_mask, 24'h0} >> {res_cnt, 3'b000});
    assign total = {1'b0, res_cnt} + in_cnt;

    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        drop         = 1'b0;
        push_word    = cat[55:24];
        push_bytes   = 3'd4;
        res_data_nxt = res_data;
        res_cnt_nxt  = res_cnt;
        case (state)
            RUN: begin
                if (total[2]) begin
                    // Encoder cannot stall: if the FIFO has no room the word
                    // is lost but packing continues from the remainder.
                    push         = can_push;
                    drop         = !can_push;
                    res_data_nxt = cat[23:0];
                end else begin
                    res_data_nxt = cat[55:32];
                end
                res_cnt_nxt = total[1:0];
                if (flush) state_nxt = MARK0;
            end
            MARK0, MARK1: begin
                // Marker bytes are never dropped; wait for room instead.
                if (can_push) begin
                    push         = 1'b1;
                    res_data_nxt = cat[23:0];
                    res_cnt_nxt  = total[1:0];
                    state_nxt    = (state == MARK0) ? MARK1 : TAIL;
                end
            end
            TAIL: begin
                if (res_cnt == 2'd0) begin
                    state_nxt = DONE;
                end else if (can_push) begin
                    push         = 1'b1;
                    push_word    = {res_data, 8'h0};
                    push_bytes   = {1'b0, res_cnt};
                    res_data_nxt = 24'h0;
                    res_cnt_nxt  = 2'd0;
                    state_nxt    = DONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            res_data <= 24'h0;
            res_cnt  <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            res_data <= res_data_nxt;
            res_cnt  <= res_cnt_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage needs no reset; the outputs are gated by fifo_empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_word[wr_ptr[AW-1:0]]  <= push_word;
            fifo_bytes[wr_ptr[AW-1:0]] <= push_bytes;
        end
    end

endmodule

// File: doc/qoi_chunk_packer.md
QOI_CHUNK_PACKER -- requirements
Module: qoi_chunk_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output word FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port chunk  input  32  encoder chunk, left-justified; stream byte 0 = chunk[31:24].
REQ-005 SHALL have port chunk_bytes  input  3  valid bytes in chunk this cycle, 0..4; values 5..7 are treated as 0.
REQ-006 SHALL have port flush  input  1  single-cycle end-of-image request.
REQ-007 SHALL have port out_word  output  32  packed word, left-justified; byte 0 = out_word[31:24].
REQ-008 SHALL have port out_bytes  output  3  valid bytes in out_word, 1..4; 0 when out_valid=0.
REQ-009 SHALL have port out_valid  output  1  out_word holds a word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-011 SHALL have port overflow  output  1  sticky: bytes were dropped.
REQ-012 SHALL have port done  output  1  end marker and final partial word pushed.

Function
REQ-013 SHALL sample chunk/chunk_bytes every cycle with no upstream stall; the encoder cannot be back-pressured.
REQ-014 SHALL hold a residual byte accumulator of 0..3 bytes; each cycle residual+new bytes (0..7) are concatenated in stream order.
REQ-015 SHALL, when the concatenation holds >=4 bytes, push the first 4 as one word (out_bytes=4) into the FIFO and keep the remainder as residual.
REQ-016 SHALL present the FIFO head on out_word/out_bytes/out_valid; a word pushed at edge N is visible from the cycle after edge N when the FIFO was empty.
REQ-017 SHALL pop on out_valid && out_ready; push and pop in the same cycle with FIFO full SHALL succeed (pop frees the slot).
REQ-018 SHALL, when a push is required and the FIFO is full with no pop, discard those 4 bytes, set overflow, and continue packing from the remainder; overflow stays 1 until rst.
REQ-019 SHALL implement states RUN, MARK0, MARK1, TAIL, DONE; reset state RUN.
REQ-020 RUN: pack per REQ-014/015; flush=1 -> MARK0, while chunk bytes in that same cycle are still packed.
REQ-021 MARK0: inject bytes 00 00 00 00 as new input; chunk input ignored; -> MARK1 when push succeeds, stay if FIFO full and no pop (no drop, no overflow).
REQ-022 MARK1: inject 00 00 00 01 likewise; -> TAIL on success.
REQ-023 TAIL: if residual>0 push residual left-justified, low bytes zero, out_bytes=residual, when FIFO has room; then -> DONE; residual=0 -> DONE directly.
REQ-024 DONE: done=1, chunk and flush ignored; FIFO continues to drain; exits only via rst.
REQ-025 flush while not in RUN SHALL be ignored.

Reset
REQ-026 On rst=1 at an edge: FIFO emptied, residual=0, state=RUN; out_valid=0, out_bytes=0, out_word=0, overflow=0, done=0 next cycle; chunk input in that cycle discarded.
REQ-027 rst mid-flush or with FIFO non-empty SHALL discard all pending data with no partial output.

Verification
REQ-028 1-byte chunks 0x11,0x22,0x33,0x44 in cycles 0..3, out_ready=1 -> cycle 4 out_word=0x11223344, out_bytes=4, out_valid=1 for one cycle.
REQ-029 chunks {0xFE010203,4},{0x40,1},{0x8A1B,2},{0x05,1} -> words 0xFE010203, then 0x408A1B05; residual 0; no overflow.
REQ-030 chunk {0xAA,1} then flush -> words 0xAA000000(4), 0x00000000(4), 0x01000000(1); done=1 after last push.
REQ-031 out_ready=0, five consecutive 4-byte chunks, FIFO_DEPTH=4 -> 4 words held, overflow=1 on cycle after fifth; raising out_ready drains exactly the first 4 words.
REQ-032 flush with FIFO full and out_ready=0 -> state holds in MARK0, no overflow; out_ready=1 -> all marker words emitted in order, done=1.
REQ-033 rst asserted in MARK1 -> next cycle out_valid=0, done=0, overflow=0; fresh 4-byte chunk packs normally.
